// File: rtl/u_rr_arb_pkg.sv
// rtl/u_rr_arb_pkg.sv - shared types and helpers for the round-robin arbiter
package u_rr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Modulo-w increment; the wrap is explicit because w need not be a power of two.
  function automatic int ptr_inc(input int id, input int w);
    return (id >= w - 1) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/u_rr_sel.sv
// rtl/u_rr_sel.sv - pivot-masked round-robin winner selection (combinational)
module u_rr_sel
  import u_rr_arb_pkg::*;
#(
  parameter int W = 4,
  localparam int IDW = $clog2(W)
) (
  input  logic [W-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic [W-1:0]   o_gnt,
  output logic [IDW-1:0] o_gnt_id
);

  logic [W-1:0]   w_hi;
  logic [W-1:0]   w_hi_gnt;
  logic [W-1:0]   w_lo_gnt;
  logic [IDW-1:0] w_hi_id;
  logic [IDW-1:0] w_lo_id;
  logic           w_hi_any;

  always_comb begin
    w_hi = '0;
    for (int i = 0; i < W; i++) begin
      w_hi[i] = i_req[i] && (i >= int'(i_ptr));
    end
  end

  // Descending scan: the last hit written is the lowest set bit.
  always_comb begin
    w_hi_gnt = '0;
    w_hi_id  = '0;
    w_lo_gnt = '0;
    w_lo_id  = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (w_hi[i]) begin
        w_hi_gnt = '0;
        w_hi_gnt[i] = 1'b1;
        w_hi_id = IDW'(i);
      end
      if (i_req[i]) begin
        w_lo_gnt = '0;
        w_lo_gnt[i] = 1'b1;
        w_lo_id = IDW'(i);
      end
    end
  end

  assign w_hi_any = |w_hi;
  assign o_gnt    = w_hi_any ? w_hi_gnt : w_lo_gnt;
  assign o_gnt_id = w_hi_any ? w_hi_id  : w_lo_id;

endmodule

// File: rtl/u_rr_arb.sv
// rtl/u_rr_arb.sv - round-robin arbiter with registered grant held until handshake
module u_rr_arb
  import u_rr_arb_pkg::*;
#(
  parameter int W = 4,
  localparam int IDW = $clog2(W)
) (
  input  logic           i_clk,
  input  logic           i_arst_n,
  input  logic [W-1:0]   i_req,
  input  logic           i_rdy,
  output logic           o_vld,
  output logic [W-1:0]   o_gnt,
  output logic [IDW-1:0] o_gnt_id,
  output logic [IDW-1:0] o_ptr
);

  state_t         r_state;
  logic           r_vld;
  logic [W-1:0]   r_gnt;
  logic [IDW-1:0] r_gnt_id;
  logic [IDW-1:0] r_ptr;

  logic           w_any;
  logic [IDW-1:0] w_ptr_nxt;
  logic [IDW-1:0] w_sel_ptr;
  logic [W-1:0]   w_sel_gnt;
  logic [IDW-1:0] w_sel_id;

  assign w_any     = |i_req;
  assign w_ptr_nxt = IDW'(ptr_inc(int'(r_gnt_id), W));
  // A back-to-back re-arbitration must already see the post-handshake pointer.
  assign w_sel_ptr = (r_state == GRANT) ? w_ptr_nxt : r_ptr;

  u_rr_sel #(
    .W (W)
  ) u_sel (
    .i_req    (i_req),
    .i_ptr    (w_sel_ptr),
    .o_gnt    (w_sel_gnt),
    .o_gnt_id (w_sel_id)
  );

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state  <= IDLE;
      r_vld    <= 1'b0;
      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_ptr    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state  <= GRANT;
            r_vld    <= 1'b1;
            r_gnt    <= w_sel_gnt;
            r_gnt_id <= w_sel_id;
          end
        end
        GRANT: begin
          if (i_rdy) begin
            r_ptr <= w_ptr_nxt;
            if (w_any) begin
              r_gnt    <= w_sel_gnt;
              r_gnt_id <= w_sel_id;
            end else begin
              r_state  <= IDLE;
              r_vld    <= 1'b0;
              r_gnt    <= '0;
              r_gnt_id <= '0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_vld   <= 1'b0;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  assign o_vld    = r_vld;
  assign o_gnt    = r_gnt;
  assign o_gnt_id = r_gnt_id;
  assign o_ptr    = r_ptr;

  a_gnt_onehot: assert property (@(posedge i_clk) disable iff (!i_arst_n)
    $onehot0(r_gnt));
  a_vld_matches_gnt: assert property (@(posedge i_clk) disable iff (!i_arst_n)
    r_vld == (|r_gnt));
  a_gnt_stable: assert property (@(posedge i_clk) disable iff (!i_arst_n)
    (r_vld && !i_rdy) |=> $stable(r_gnt));
  a_ptr_range: assert property (@(posedge i_clk) disable iff (!i_arst_n)
    int'(r_ptr) < W);
  // Requester must hold its request while stalled; dropping it in the handshake cycle is legal.
  a_req_held: assert property (@(posedge i_clk) disable iff (!i_arst_n)
    (r_vld && !i_rdy) |-> (|(i_req & r_gnt)));

endmodule

// File: tb/tb_u_rr_arb.sv
// tb/tb_u_rr_arb.sv - directed self-checking bench for u_rr_arb (W=4)
module tb_u_rr_arb;

  localparam int W = 4;
  localparam int IDW = 2;

  logic           clk;
  logic           arst_n;
  logic [W-1:0]   req;
  logic           rdy;
  logic           vld;
  logic [W-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic [IDW-1:0] ptr;

  int n_checks;
  int n_pass;

  u_rr_arb #(
    .W (W)
  ) dut (
    .i_clk    (clk),
    .i_arst_n (arst_n),
    .i_req    (req),
    .i_rdy    (rdy),
    .o_vld    (vld),
    .o_gnt    (gnt),
    .o_gnt_id (gnt_id),
    .o_ptr    (ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_grant(input string tag, input logic [W-1:0] exp_gnt,
                             input logic [IDW-1:0] exp_id, input logic [IDW-1:0] exp_ptr);
    check({tag, ".vld"}, 32'(vld), 32'(exp_gnt != '0));
    check({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
    check({tag, ".id"},  32'(gnt_id), 32'(exp_id));
    check({tag, ".ptr"}, 32'(ptr), 32'(exp_ptr));
  endtask

  logic [W-1:0]   full_gnt [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                   4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [IDW-1:0] full_id  [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [IDW-1:0] full_ptr [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [W-1:0]   stall_req [5] = '{4'b0010, 4'b0110, 4'b1110, 4'b1110, 4'b1110};

  initial begin
    n_checks = 0;
    n_pass   = 0;
    arst_n   = 1'b0;
    req      = 4'b1111;
    rdy      = 1'b1;

    // Reset held with all requesting
    step();
    step();
    check_grant("reset", 4'b0000, 2'd0, 2'd0);
    arst_n = 1'b1;

    // Full load, no bubbles
    step();
    for (int i = 0; i < 8; i++) begin
      check_grant($sformatf("full%0d", i), full_gnt[i], full_id[i], full_ptr[i]);
      if (i < 7) step();
    end

    // Set up grant 0010 with ptr=1
    req = 4'b0011;
    step();
    check_grant("setup0", 4'b0001, 2'd0, 2'd0);
    req = 4'b0010;
    step();
    check_grant("setup1", 4'b0010, 2'd1, 2'd1);

    // Backpressure
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req = stall_req[i];
      step();
      check_grant($sformatf("stall%0d", i), 4'b0010, 2'd1, 2'd1);
    end
    rdy = 1'b1;
    step();
    check_grant("unstall", 4'b0100, 2'd2, 2'd2);

    // Wrap past the top of the vector
    req = 4'b0011;
    step();
    check_grant("wrap0", 4'b0001, 2'd0, 2'd3);
    step();
    check_grant("wrap1", 4'b0010, 2'd1, 2'd1);

    // Single requester held
    req = 4'b1000;
    step();
    check_grant("single0", 4'b1000, 2'd3, 2'd2);
    step();
    check_grant("single1", 4'b1000, 2'd3, 2'd0);
    step();
    check_grant("single2", 4'b1000, 2'd3, 2'd0);
    req = 4'b0000;
    step();
    check_grant("drop", 4'b0000, 2'd0, 2'd0);
    step();
    check_grant("idle", 4'b0000, 2'd0, 2'd0);

    // Reset mid-grant with a nonzero pointer
    req = 4'b0010;
    step();
    check_grant("mid0", 4'b0010, 2'd1, 2'd0);
    req = 4'b0100;
    step();
    check_grant("mid1", 4'b0100, 2'd2, 2'd2);
    rdy = 1'b0;
    step();
    check_grant("mid2", 4'b0100, 2'd2, 2'd2);
    #1 arst_n = 1'b0;
    #1;
    check_grant("async_rst", 4'b0000, 2'd0, 2'd0);
    step();
    check_grant("rst_hold", 4'b0000, 2'd0, 2'd0);
    arst_n = 1'b1;
    step();
    check_grant("post_rst", 4'b0100, 2'd2, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/u_rr_arb.md
Name: u_rr_arb

Overview:
- Round-robin arbiter that shares one downstream resource between W requesters over a valid/ready handshake.
- Selection uses pivot masking: requests at or above a rotating pointer are considered first, with wrap-around to the full request vector.
- The grant is registered and held stable until the downstream handshake completes.
- Sits in front of any shared port (memory, bus, lookup engine) in the u library.

Parameters:
- W, 4, number of requesters; must be >= 2.
- IDW, $clog2(W), width of the encoded grant index; derived, not overridden.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_arst_n  in  1  asynchronous, active-low reset.
- i_req  in  W  per-requester request level.
- i_rdy  in  1  downstream ready.
- o_vld  out  1  grant valid to downstream.
- o_gnt  out  W  one-hot grant; all zeros when o_vld=0.
- o_gnt_id  out  IDW  encoded index of the o_gnt bit; 0 when o_vld=0.
- o_ptr  out  IDW  current priority pointer (debug/visibility).

Behaviour:
- Reset (async assert, sync deassert handled externally): state=IDLE, o_vld=0, o_gnt=0, o_gnt_id=0, o_ptr=0.
- Reset asserted mid-grant clears everything immediately; the in-flight grant is dropped, with no handshake.
- State machine, two states:
  - IDLE: if |i_req, register winner=sel(i_req, ptr), go to GRANT with o_vld=1 next cycle. Otherwise stay in IDLE.
  - GRANT: o_vld=1, o_gnt/o_gnt_id constant while i_rdy=0, regardless of i_req changes.
  - GRANT, handshake (o_vld & i_rdy): ptr <= (winner_id+1) mod W; the wrap is explicit, since W need not be a power of 2.
    - If |i_req that same cycle: re-arbitrate with the updated pointer and load the new winner. Stay in GRANT, back-to-back, zero bubble.
    - Else: go to IDLE, o_vld=0 next cycle.
- sel(req, p):
  - hi = req with bits below p forced to 0 (MSB-side pivot mask).
  - If hi != 0, winner = lowest set bit of hi; else winner = lowest set bit of req.
  - Result is one-hot. Never called with req=0.
- i_req in the handshake cycle is read as "has another request". A requester that keeps i_req high is eligible again, but at lowest priority.
- Latency: request to o_vld is 1 cycle from IDLE. Sustained throughput is 1 grant/cycle with i_rdy=1.
- Requester protocol: i_req must stay high while granted until the handshake. Dropping it early is a protocol violation; the grant is still held and an assertion fires.
- Pointer changes only on a handshake. Never on reset release, and never while stalled.
- Fairness bound: with all W requesting and i_rdy=1, every requester is granted exactly once per W consecutive grants.
- Assertions:
  - $onehot0(o_gnt).
  - o_vld == |o_gnt.
  - o_gnt stable while o_vld & !i_rdy.
  - o_ptr < W.

Decomposition:
- Package u_rr_arb_pkg: state enum (IDLE, GRANT), helper function ptr_inc(id, W) for the modulo-W increment.
- Sub-module u_rr_sel (combinational): inputs req[W], ptr[IDW]; outputs one-hot gnt[W] and gnt_id[IDW].
  - Internally builds the pivot mask and two find-first-set chains.
  - Instantiated once; the FSM, grant register and pointer stay in u_rr_arb.

Test Plan (W=4):
- Reset: hold i_arst_n=0 with i_req=4'b1111 -> o_vld=0, o_gnt=0, o_ptr=0. Release -> o_gnt=0001 on the next edge.
- Full load: i_req=1111, i_rdy=1 for 8 cycles -> o_gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000, with no bubbles.
- Backpressure: grant 0010 outstanding, i_rdy=0 for 5 cycles while i_req goes 0010→1110 -> o_gnt stays 0010, o_ptr stays 1. i_rdy=1 -> next grant 0100, o_ptr=2.
- Wrap: after a handshake on requester 2 (o_ptr=3), i_req=0011 -> o_gnt=0001, o_gnt_id=0. Then o_ptr=1 -> o_gnt=0010.
- Single requester: i_req=1000 held, i_rdy=1 -> o_gnt=1000 every cycle, o_ptr stays 0 after each handshake. Drop i_req with i_rdy=1 -> o_vld=0 next cycle.
- Reset mid-grant: o_gnt=0100, i_rdy=0, assert i_arst_n=0 asynchronously -> o_vld and o_gnt go to 0 before the next edge, o_ptr=0. After release with i_req=0100 -> o_gnt=0100.
